// File: rtl/vec_alu_pkg.sv
// Shared types and constants for the 4-lane vector ALU.
// The optional alpha-lane passthrough is enabled by defining VALU_ALPHA_EN.
package vec_alu_pkg;

  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_W    = 32;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned PIX_MAX   = 255;
  localparam int unsigned PROD_W    = 2 * PIX_W;
  localparam int unsigned VEC_W     = LANES * LANE_W;
  localparam int unsigned PIX_LANES = 3;

  // Vx control word layout: {k, M1, M2}
  localparam int unsigned VX_W      = 56;
  localparam int unsigned VX_K_LSB  = 48;
  localparam int unsigned VX_M1_LSB = 24;
  localparam int unsigned VX_M2_LSB = 0;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_VOPG  = 3'b001,
    OP_VOPA  = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_e;

  // Clamp a 16-bit product to the pixel range
  function automatic logic [PIX_W-1:0] sat_pix(input logic [PROD_W-1:0] v);
    if (v > PROD_W'(PIX_MAX)) begin
      return PIX_W'(PIX_MAX);
    end
    return v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/vec_alu_core_if.sv
// Operand/result bundle between the vector issue logic and vec_alu_core.
interface vec_alu_core_if;
  import vec_alu_pkg::*;

  logic                in_valid;
  logic                vc_sub;
  alu_op_e             alu_op;
  logic [VEC_W-1:0]    input_a;
  logic [VEC_W-1:0]    input_b;
  logic [VX_W-1:0]     vx;
  logic [VEC_W-1:0]    out;
  logic                out_valid;

  modport master (
    output in_valid, vc_sub, alu_op, input_a, input_b, vx,
    input  out, out_valid
  );

  modport slave (
    input  in_valid, vc_sub, alu_op, input_a, input_b, vx,
    output out, out_valid
  );

endinterface

// File: rtl/vec_alu_pixel_lane.sv
// Combinational vopg/vopa datapath for one 8-bit colour lane.
module vec_alu_pixel_lane
  import vec_alu_pkg::*;
(
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  input  logic [PIX_W-1:0] k_i,
  input  logic             m1_i,
  input  logic             m2_i,
  input  logic             vc_sub_i,
  input  alu_op_e          op_i,
  output logic [PIX_W-1:0] res_o_c
);

  logic [PROD_W-1:0] prod_ak;
  logic [PROD_W-1:0] prod_kd;
  logic [PIX_W-1:0]  a_div10;
  logic [PIX_W-1:0]  a_modk;
  logic [PIX_W-1:0]  vopg_res;
  logic [PIX_W-1:0]  vopa_res;

  // vopg: mask code {M1 bit, M2 bit} picks gain, decimated gain, modulo or zero
  always_comb begin
    prod_ak  = PROD_W'(a_i) * PROD_W'(k_i);
    a_div10  = a_i / PIX_W'(10);
    prod_kd  = PROD_W'(k_i) * PROD_W'(a_div10);
    a_modk   = (k_i == '0) ? a_i : (a_i % k_i);
    vopg_res = '0;
    case ({m1_i, m2_i})
      2'b11:   vopg_res = sat_pix(prod_ak);
      2'b01:   vopg_res = sat_pix(prod_kd);
      2'b10:   vopg_res = a_modk;
      default: vopg_res = '0;
    endcase
  end

  // vopa: min, or subtract clamped at zero
  always_comb begin
    vopa_res = '0;
    if (vc_sub_i) begin
      vopa_res = (a_i > b_i) ? (a_i - b_i) : '0;
    end else begin
      vopa_res = (a_i < b_i) ? a_i : b_i;
    end
  end

  always_comb begin
    res_o_c = '0;
    if (op_i == OP_VOPG) begin
      res_o_c = vopg_res;
    end else if (op_i == OP_VOPA) begin
      res_o_c = vopa_res;
    end
  end

endmodule

// File: rtl/vec_alu_core.sv
// Registered 4-lane SIMD ALU: element-wise integer ops plus vopg/vopa pixel ops.
// Define VALU_ALPHA_EN to pass lane 3 of A through for pixel ops instead of zeroing it.
module vec_alu_core
  import vec_alu_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  vec_alu_core_if.slave bus
);

  logic [VEC_W-1:0] pix_vec;
  logic [VEC_W-1:0] out_d;
  logic [VEC_W-1:0] out_q;
  logic             out_valid_q;

  // Colour lanes 0..2 share k; each lane decodes bit 0 of its own mask bytes
  for (genvar l = 0; l < PIX_LANES; l++) begin : g_pix
    logic [PIX_W-1:0] lane_res;

    vec_alu_pixel_lane u_lane (
      .a_i      (bus.input_a[l*LANE_W +: PIX_W]),
      .b_i      (bus.input_b[l*LANE_W +: PIX_W]),
      .k_i      (bus.vx[VX_K_LSB +: PIX_W]),
      .m1_i     (bus.vx[VX_M1_LSB + l*PIX_W]),
      .m2_i     (bus.vx[VX_M2_LSB + l*PIX_W]),
      .vc_sub_i (bus.vc_sub),
      .op_i     (bus.alu_op),
      .res_o_c  (lane_res)
    );

    assign pix_vec[l*LANE_W +: LANE_W] = LANE_W'(lane_res);
  end

`ifdef VALU_ALPHA_EN
  assign pix_vec[PIX_LANES*LANE_W +: LANE_W] = bus.input_a[PIX_LANES*LANE_W +: LANE_W];
`else
  assign pix_vec[PIX_LANES*LANE_W +: LANE_W] = '0;
`endif

  // Result mux; add/sub are per lane so carries never cross lane boundaries
  always_comb begin
    out_d = '0;
    case (bus.alu_op)
      OP_ADD: begin
        for (int l = 0; l < LANES; l++) begin
          out_d[l*LANE_W +: LANE_W] = bus.input_a[l*LANE_W +: LANE_W]
                                    + bus.input_b[l*LANE_W +: LANE_W];
        end
      end
      OP_SUB: begin
        for (int l = 0; l < LANES; l++) begin
          out_d[l*LANE_W +: LANE_W] = bus.input_a[l*LANE_W +: LANE_W]
                                    - bus.input_b[l*LANE_W +: LANE_W];
        end
      end
      OP_VOPG,
      OP_VOPA:  out_d = pix_vec;
      OP_AND:   out_d = bus.input_a & bus.input_b;
      OP_OR:    out_d = bus.input_a | bus.input_b;
      OP_XOR:   out_d = bus.input_a ^ bus.input_b;
      OP_PASSB: out_d = bus.input_b;
      default:  out_d = '0;
    endcase
  end

  // Output register updates every cycle; valid just tracks in_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= bus.in_valid;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_vec_alu_core.sv
// Directed self-checking bench for vec_alu_core (honours VALU_ALPHA_EN for lane 3).
module tb_vec_alu_core;
  import vec_alu_pkg::*;

`ifdef VALU_ALPHA_EN
  localparam bit ALPHA = 1'b1;
`else
  localparam bit ALPHA = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  vec_alu_core_if bus ();

  vec_alu_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VEC_W-1:0] vec4(input logic [31:0] l3, input logic [31:0] l2,
                                            input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Drive one operation at the falling edge, then sample just after the rising edge
  task automatic run_op(input logic vld, input alu_op_e op, input logic vc,
                        input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                        input logic [VX_W-1:0] vxw);
    @(negedge clk);
    bus.in_valid = vld;
    bus.alu_op   = op;
    bus.vc_sub   = vc;
    bus.input_a  = a;
    bus.input_b  = b;
    bus.vx       = vxw;
    @(posedge clk);
    #1;
  endtask

  logic [VEC_W-1:0] a_v, b_v, exp_v;
  logic [31:0]      l3_exp;

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_op   = OP_ADD;
    bus.vc_sub   = 1'b0;
    bus.input_a  = '0;
    bus.input_b  = '0;
    bus.vx       = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", bus.out, '0);
    chk("reset_valid", VEC_W'(bus.out_valid), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // vopg mask decode: codes 11, 01, 10, 00 on lanes 0..2 (lane 2 code 10)
    a_v    = vec4(32'd103, 32'd102, 32'd101, 32'd100);
    b_v    = vec4(32'd103, 32'd103, 32'd103, 32'd103);
    l3_exp = ALPHA ? 32'd103 : 32'd0;
    run_op(1'b1, OP_VOPG, 1'b0, a_v, b_v, {8'd25, 24'hFF00FF, 24'h00FFFF});
    chk("vopg_decode", bus.out, vec4(l3_exp, 32'd2, 32'd250, 32'd255));
    chk("vopg_valid", VEC_W'(bus.out_valid), VEC_W'(1));

    run_op(1'b1, OP_VOPA, 1'b0, a_v, b_v, {8'd25, 24'hFF00FF, 24'h00FFFF});
    chk("vopa_min", bus.out, vec4(l3_exp, 32'd102, 32'd101, 32'd100));

    // Saturating subtract; upper lane bits of A are junk and must be ignored
    a_v    = vec4(32'hDEAD_BEEF, 32'd103, 32'h0000_AB05, 32'h1234_56C8);
    l3_exp = ALPHA ? 32'hDEAD_BEEF : 32'd0;
    run_op(1'b1, OP_VOPA, 1'b1, a_v, b_v, '0);
    chk("vopa_sub", bus.out, vec4(l3_exp, 32'd0, 32'd0, 32'd97));

    // k=0: lane0 code 10 -> a, lane1 code 11 -> 0, lane2 code 01 -> 0; extra mask bits set
    a_v    = vec4(32'd5, 32'd200, 32'd77, 32'd77);
    l3_exp = ALPHA ? 32'd5 : 32'd0;
    run_op(1'b1, OP_VOPG, 1'b0, a_v, b_v, {8'd0, 24'h0003FD, 24'h1101FE});
    chk("vopg_k0", bus.out, vec4(l3_exp, 32'd0, 32'd0, 32'd77));

    // k=7: 250 mod 7 = 5, 7*floor(99/10) = 63, 36*7 = 252 (no clamp)
    a_v    = vec4(32'd9, 32'd36, 32'd99, 32'd250);
    l3_exp = ALPHA ? 32'd9 : 32'd0;
    run_op(1'b1, OP_VOPG, 1'b0, a_v, b_v, {8'd7, 24'h010001, 24'h010100});
    chk("vopg_k7", bus.out, vec4(l3_exp, 32'd252, 32'd63, 32'd5));

    run_op(1'b1, OP_ADD, 1'b0, {4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, '0);
    chk("add_wrap", bus.out, '0);

    run_op(1'b1, OP_ADD, 1'b0, vec4(32'd1, 32'd2, 32'd3, 32'h7FFF_FFFF),
           vec4(32'd10, 32'd20, 32'd30, 32'd1), '0);
    chk("add_lanes", bus.out, vec4(32'd11, 32'd22, 32'd33, 32'h8000_0000));

    run_op(1'b1, OP_SUB, 1'b0, '0, {4{32'h0000_0001}}, '0);
    chk("sub_wrap", bus.out, {4{32'hFFFF_FFFF}});

    a_v = {4{32'hF0F0_F0F0}};
    b_v = {4{32'hFF00_FF00}};
    run_op(1'b1, OP_AND, 1'b0, a_v, b_v, '0);
    chk("and", bus.out, {4{32'hF000_F000}});
    run_op(1'b1, OP_OR, 1'b0, a_v, b_v, '0);
    chk("or", bus.out, {4{32'hFFF0_FFF0}});
    run_op(1'b1, OP_XOR, 1'b0, a_v, b_v, '0);
    chk("xor", bus.out, {4{32'h0FF0_0FF0}});
    run_op(1'b1, OP_PASSB, 1'b0, a_v, b_v, '0);
    chk("passb", bus.out, b_v);

    // out still updates when in_valid is low
    run_op(1'b0, OP_PASSB, 1'b0, a_v, {4{32'h1357_9BDF}}, '0);
    chk("idle_out", bus.out, {4{32'h1357_9BDF}});
    chk("idle_valid", VEC_W'(bus.out_valid), '0);

    // Asynchronous reset mid-cycle, with in_valid pending
    run_op(1'b1, OP_PASSB, 1'b0, a_v, b_v, '0);
    chk("pre_rst_valid", VEC_W'(bus.out_valid), VEC_W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", bus.out, '0);
    chk("async_rst_valid", VEC_W'(bus.out_valid), '0);
    @(posedge clk);
    #1;
    chk("rst_wins_valid", VEC_W'(bus.out_valid), '0);
    chk("rst_wins_out", bus.out, '0);

    // Release with in_valid already high: captured at the very next edge
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_valid", VEC_W'(bus.out_valid), '0);
    @(posedge clk);
    #1;
    chk("first_valid", VEC_W'(bus.out_valid), VEC_W'(1));
    chk("first_out", bus.out, b_v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
